// File: rtl/veri_risc_pkg.sv
// Shared definitions for the Veri_Risc CPU blocks.
//   - Opcode encodings carried in IR[7:5].
//   - Phase encodings of the 8-phase instruction cycle.
//   - is_aluop(): true for instructions that load the accumulator from the ALU.
package veri_risc_pkg;

   // Opcodes
   localparam logic [2:0] HLT = 3'd0;
   localparam logic [2:0] SKZ = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] LDA = 3'd5;
   localparam logic [2:0] STO = 3'd6;
   localparam logic [2:0] JMP = 3'd7;

   // Instruction-cycle phases
   localparam logic [2:0] INST_ADDR  = 3'd0;
   localparam logic [2:0] INST_FETCH = 3'd1;
   localparam logic [2:0] INST_LOAD  = 3'd2;
   localparam logic [2:0] IDLE       = 3'd3;
   localparam logic [2:0] OP_ADDR    = 3'd4;
   localparam logic [2:0] OP_FETCH   = 3'd5;
   localparam logic [2:0] ALU_OP     = 3'd6;
   localparam logic [2:0] STORE      = 3'd7;

   function automatic logic is_aluop(input logic [2:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/risc_phase_counter.sv
// 3-bit instruction-phase counter.
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low clear (phase -> 0)
//   i_hold  in   1 = keep current phase this cycle
//   o_phase out  current phase, advances +1 per clock and wraps 7 -> 0
module risc_phase_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_hold,
   output logic [2:0] o_phase
);

   logic [2:0] r_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 3'd0;
      end else if (!i_hold) begin
         r_phase <= r_phase + 3'd1;
      end
   end

   assign o_phase = r_phase;

endmodule

// File: rtl/risc_controller.sv
// Veri_Risc instruction sequencer: steps each instruction through 8 phases,
// decodes the opcode and drives the datapath/memory strobes. Supports a
// sticky halt released by an external resume, and counts retired instructions.
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, zero        IR[7:5] and accumulator-zero flag
//   resume              release a halted HLT (level, sampled on clk)
//   sel, rd, ld_ir      address mux (1=PC), memory read, IR load
//   inc_pc, ld_pc       PC increment / PC load from operand
//   ld_ac, wr, data_e   AC load, memory write, AC drives data bus
//   halt                CPU halted
//   phase               current phase (debug)
//   instr_cnt           retired instructions since reset, wraps
module risc_controller
   import veri_risc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       opcode,
   input  logic             zero,
   input  logic             resume,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             ld_pc,
   output logic             ld_ac,
   output logic             wr,
   output logic             data_e,
   output logic             halt,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] instr_cnt
);

   logic [2:0]       w_phase;
   logic             w_hold;
   logic             w_aluop;
   logic [CNT_W-1:0] r_instr_cnt;

   // HLT parks the sequencer in OP_ADDR until resume is seen on a clock edge.
   assign w_hold  = (w_phase == OP_ADDR) && (opcode == HLT) && !resume;
   assign w_aluop = is_aluop(opcode);

   risc_phase_counter u_phase_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (w_hold),
      .o_phase (w_phase)
   );

   // An instruction retires on the STORE -> INST_ADDR edge; STORE never holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_cnt <= '0;
      end else if (w_phase == STORE) begin
         r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
   end

   // Strobes are a pure decode of phase and inputs, so reset clears them
   // immediately through the phase register.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      unique case (w_phase)
         INST_ADDR: begin
            sel = 1'b1;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         OP_ADDR: begin
            // resume lets a halted HLT bump the PC exactly once, on the release cycle.
            inc_pc = (opcode != HLT) || resume;
            halt   = (opcode == HLT);
         end
         OP_FETCH: begin
            rd = w_aluop;
         end
         ALU_OP: begin
            rd     = w_aluop;
            inc_pc = (opcode == SKZ) && zero;
            ld_pc  = (opcode == JMP);
            data_e = (opcode == STO);
         end
         STORE: begin
            rd     = w_aluop;
            ld_ac  = w_aluop;
            ld_pc  = (opcode == JMP);
            wr     = (opcode == STO);
            data_e = (opcode == STO);
         end
         default: begin
            sel = 1'b0;
         end
      endcase
   end

   assign phase     = w_phase;
   assign instr_cnt = r_instr_cnt;

endmodule
